// File: rtl/jtexterm_obj_fetch_if.sv
// ---------------------------------------------------------------------------
// jtexterm_obj_fetch_if
// Groups the object-descriptor handshake and the graphics ROM bus used by
// jtexterm_obj_fetch.
//
// Handshake: a descriptor (obj_code/obj_xpos/obj_pal/obj_vsub/obj_hflip) is
// transferred on a rising clk edge where obj_valid and obj_ready are both
// high; the producer keeps the descriptor stable while obj_valid is high and
// obj_ready is low. On the ROM side rom_addr is held stable while rom_cs is
// high, and rom_data is taken on the first edge with rom_cs & rom_ok.
//
// Modports:
//   slave  - the fetch block (accepts descriptors, issues ROM requests)
//   master - the environment (object producer + ROM model)
// ---------------------------------------------------------------------------
interface jtexterm_obj_fetch_if;
    logic        obj_valid;
    logic        obj_ready;
    logic [11:0] obj_code;
    logic [8:0]  obj_xpos;
    logic [3:0]  obj_pal;
    logic [3:0]  obj_vsub;
    logic        obj_hflip;
    logic        rom_cs;
    logic [19:0] rom_addr;
    logic [31:0] rom_data;
    logic        rom_ok;

    modport slave (
        input  obj_valid, obj_code, obj_xpos, obj_pal, obj_vsub, obj_hflip,
        input  rom_data, rom_ok,
        output obj_ready, rom_cs, rom_addr
    );

    modport master (
        output obj_valid, obj_code, obj_xpos, obj_pal, obj_vsub, obj_hflip,
        output rom_data, rom_ok,
        input  obj_ready, rom_cs, rom_addr
    );
endinterface

// File: rtl/jtexterm_obj_fetch.sv
// ---------------------------------------------------------------------------
// jtexterm_obj_fetch
// Object (sprite) line renderer: takes 16-pixel-wide object descriptors,
// fetches two 32-bit ROM words per object (8 x 4bpp pixels each), and paints
// the non-transparent pixels into a 256-entry write line buffer. A second
// line buffer is read out for display and cleared behind the beam.
//
// Ports:
//   clk, rstn    - clock, synchronous active-low reset
//   pxl_cen      - pixel clock enable; triggers one readout of hdump
//   line_start   - HS pulse: swaps line buffers, aborts any object in flight
//   hdump        - displayed column (bit 8 set = off-screen, reads 0)
//   bus          - descriptor handshake + ROM bus (slave modport)
//   busy         - high whenever the FSM is not idle
//   pxl_dout     - {pal,pix} of the last pixel read, 0 = transparent
//   state_dbg    - current FSM state (IDLE=0, REQ=1, DRAW=2)
//
// Optional feature: define JTEXTERM_OBJ_HFLIP_EN to honour obj_hflip
// (mirrors nibble order and swaps which half lands at xpos). Without it
// obj_hflip is ignored.
// ---------------------------------------------------------------------------
module jtexterm_obj_fetch (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    pxl_cen,
    input  logic                    line_start,
    input  logic [8:0]              hdump,
    jtexterm_obj_fetch_if.slave     bus,
    output logic                    busy,
    output logic [7:0]              pxl_dout,
    output logic [1:0]              state_dbg
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DRAW = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        half_q, half_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] data_q, data_d;
    logic [19:0] rom_addr_q, rom_addr_d;
    logic [11:0] code_q, code_d;
    logic [8:0]  xpos_q, xpos_d;
    logic [3:0]  pal_q, pal_d;
    logic [3:0]  vsub_q, vsub_d;
    logic        bufsel_q;
    logic [7:0]  pxl_dout_q;
    logic        accept;
    logic        hf;

    // bufsel_q==0: buffer 0 is being filled, buffer 1 is displayed
    logic [7:0]  ram0 [0:255];
    logic [7:0]  ram1 [0:255];

    assign bus.obj_ready = rstn & (state_q == ST_IDLE) & ~line_start;
    assign accept        = bus.obj_valid & bus.obj_ready;
    // rom_cs is tied to the REQ state, so it can never be high elsewhere
    assign bus.rom_cs    = (state_q == ST_REQ);
    assign bus.rom_addr  = rom_addr_q;
    assign busy          = (state_q != ST_IDLE);
    assign pxl_dout      = pxl_dout_q;
    assign state_dbg     = state_q;

`ifdef JTEXTERM_OBJ_HFLIP_EN
    logic hflip_q;
    always_ff @(posedge clk) begin
        if (!rstn)       hflip_q <= 1'b0;
        else if (accept) hflip_q <= bus.obj_hflip;
    end
    assign hf = hflip_q;
`else
    logic unused_hflip;
    assign unused_hflip = bus.obj_hflip;
    assign hf = 1'b0;
`endif

    // Pixel selection: mirrored objects read nibbles 7..0 and draw the
    // first-fetched half (half 0) on the right.
    logic [2:0] nib_sel;
    logic [3:0] nib;
    logic [8:0] wr_x;
    logic       wr_en;

    assign nib_sel = hf ? ~cnt_q : cnt_q;
    assign nib     = data_q[{nib_sel, 2'b00} +: 4];
    assign wr_x    = xpos_q + {5'd0, half_q ^ hf, 3'd0} + {6'd0, cnt_q};
    // No write on the line_start clock: the object is being aborted
    assign wr_en   = (state_q == ST_DRAW) & ~line_start & (nib != 4'd0) & ~wr_x[8];

    always_comb begin
        state_d    = state_q;
        half_d     = half_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        rom_addr_d = rom_addr_q;
        code_d     = code_q;
        xpos_d     = xpos_q;
        pal_d      = pal_q;
        vsub_d     = vsub_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    code_d     = bus.obj_code;
                    xpos_d     = bus.obj_xpos;
                    pal_d      = bus.obj_pal;
                    vsub_d     = bus.obj_vsub;
                    half_d     = 1'b0;
                    rom_addr_d = {bus.obj_code, bus.obj_vsub, 1'b0, 3'b000};
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (line_start) begin
                    state_d = ST_IDLE;
                end else if (bus.rom_ok) begin
                    data_d  = bus.rom_data;
                    cnt_d   = 3'd0;
                    state_d = ST_DRAW;
                end
            end
            ST_DRAW: begin
                if (line_start) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        if (!half_q) begin
                            half_d     = 1'b1;
                            rom_addr_d = {code_q, vsub_q, 1'b1, 3'b000};
                            state_d    = ST_REQ;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            half_q     <= 1'b0;
            cnt_q      <= 3'd0;
            data_q     <= 32'd0;
            rom_addr_q <= 20'd0;
            code_q     <= 12'd0;
            xpos_q     <= 9'd0;
            pal_q      <= 4'd0;
            vsub_q     <= 4'd0;
            bufsel_q   <= 1'b0;
            pxl_dout_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            half_q     <= half_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            rom_addr_q <= rom_addr_d;
            code_q     <= code_d;
            xpos_q     <= xpos_d;
            pal_q      <= pal_d;
            vsub_q     <= vsub_d;
            if (line_start) bufsel_q <= ~bufsel_q;
            if (pxl_cen)
                pxl_dout_q <= hdump[8] ? 8'd0 : (bufsel_q ? ram0[hdump[7:0]] : ram1[hdump[7:0]]);
        end
    end

    // Line buffer RAM is not reset; display readout clears each entry it
    // reads so the buffer is empty again when it becomes the write buffer.
    logic rd_clr;
    assign rd_clr = pxl_cen & ~hdump[8];

    always_ff @(posedge clk) begin
        if (wr_en && !bufsel_q) ram0[wr_x[7:0]] <= {pal_q, nib};
        if (rd_clr && bufsel_q) ram0[hdump[7:0]] <= 8'd0;
    end

    always_ff @(posedge clk) begin
        if (wr_en && bufsel_q)   ram1[wr_x[7:0]] <= {pal_q, nib};
        if (rd_clr && !bufsel_q) ram1[hdump[7:0]] <= 8'd0;
    end
endmodule

// File: tb/tb_jtexterm_obj_fetch.sv
module tb_jtexterm_obj_fetch;
    logic       clk;
    logic       rstn;
    logic       pxl_cen;
    logic       line_start;
    logic [8:0] hdump;
    logic       busy;
    logic [7:0] pxl_dout;
    logic [1:0] state_dbg;

    jtexterm_obj_fetch_if bus();

    jtexterm_obj_fetch dut (
        .clk        (clk),
        .rstn       (rstn),
        .pxl_cen    (pxl_cen),
        .line_start (line_start),
        .hdump      (hdump),
        .bus        (bus),
        .busy       (busy),
        .pxl_dout   (pxl_dout),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // expected painted columns per scenario; everything else must read 0
    typedef struct {
        int         scen;
        int         col;
        logic [7:0] val;
    } col_vec_t;
    col_vec_t tbl[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input int scen, input int col, input logic [7:0] val);
        col_vec_t v;
        v.scen = scen;
        v.col  = col;
        v.val  = val;
        tbl.push_back(v);
    endtask

    // driver tasks
    task automatic send_obj(input logic [11:0] code, input logic [3:0] vsub,
                            input logic [8:0] xpos, input logic [3:0] pal, input logic hflip);
        int n = 0;
        bus.obj_code  = code;
        bus.obj_vsub  = vsub;
        bus.obj_xpos  = xpos;
        bus.obj_pal   = pal;
        bus.obj_hflip = hflip;
        bus.obj_valid = 1'b1;
        while (!bus.obj_ready && n < 50) begin
            tick();
            n++;
        end
        check("obj_ready_timeout", {31'd0, bus.obj_ready}, 32'd1);
        tick();
        bus.obj_valid = 1'b0;
    endtask

    task automatic serve_rom(input string name, input logic [19:0] exp_addr,
                             input logic [31:0] data, input int delay);
        int n = 0;
        while (!bus.rom_cs && n < 50) begin
            tick();
            n++;
        end
        check({name, "_rom_cs"}, {31'd0, bus.rom_cs}, 32'd1);
        check({name, "_rom_addr"}, {12'd0, bus.rom_addr}, {12'd0, exp_addr});
        for (int i = 0; i < delay; i++) begin
            tick();
            check({name, "_hold_cs"}, {31'd0, bus.rom_cs}, 32'd1);
            check({name, "_hold_addr"}, {12'd0, bus.rom_addr}, {12'd0, exp_addr});
            check({name, "_hold_busy"}, {31'd0, busy}, 32'd1);
        end
        bus.rom_data = data;
        bus.rom_ok   = 1'b1;
        tick();
        bus.rom_ok   = 1'b0;
        bus.rom_data = $urandom;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check({name, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic swap();
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    task automatic read_col(input logic [8:0] col, output logic [7:0] v);
        hdump   = col;
        pxl_cen = 1'b1;
        tick();
        pxl_cen = 1'b0;
        v = pxl_dout;
    endtask

    // reads all 256 columns of the display buffer (clearing it) and, when
    // asked, compares against the table entries for one scenario
    task automatic sweep_line(input int scen, input bit do_check);
        logic [7:0] exp_line [0:255];
        logic [7:0] v;
        for (int c = 0; c < 256; c++) exp_line[c] = 8'h00;
        foreach (tbl[k]) if (tbl[k].scen == scen) exp_line[tbl[k].col] = tbl[k].val;
        for (int c = 0; c < 256; c++) begin
            read_col(c[8:0], v);
            if (do_check) check($sformatf("s%0d_col%0d", scen, c), {24'd0, v}, {24'd0, exp_line[c]});
        end
    endtask

    initial begin
        logic [7:0] v;

        // expected-value table
        for (int i = 0; i < 8; i++) add_vec(1, 16 + i, 8'h31 + 8'(i));
        add_vec(1, 24, 8'h3F);
        for (int i = 0; i < 12; i++) add_vec(2, i, 8'h51);
        add_vec(3, 100, 8'hA2);
        for (int i = 0; i < 8; i++) add_vec(4, 200 + i, 8'h72);
`ifdef JTEXTERM_OBJ_HFLIP_EN
        add_vec(6, 15, 8'h61);
`else
        add_vec(6, 0, 8'h61);
`endif

        rstn          = 1'b0;
        pxl_cen       = 1'b0;
        line_start    = 1'b0;
        hdump         = 9'd0;
        bus.obj_valid = 1'b1;
        bus.obj_code  = 12'hFFF;
        bus.obj_xpos  = 9'd0;
        bus.obj_pal   = 4'd0;
        bus.obj_vsub  = 4'd0;
        bus.obj_hflip = 1'b0;
        bus.rom_data  = 32'd0;
        bus.rom_ok    = 1'b0;

        // reset state
        repeat (3) tick();
        check("rst_obj_ready", {31'd0, bus.obj_ready}, 32'd0);
        check("rst_rom_cs", {31'd0, bus.rom_cs}, 32'd0);
        check("rst_rom_addr", {12'd0, bus.rom_addr}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_pxl_dout", {24'd0, pxl_dout}, 32'd0);
        check("rst_state", {30'd0, state_dbg}, 32'd0);
        bus.obj_valid = 1'b0;
        rstn = 1'b1;
        tick();
        check("idle_obj_ready", {31'd0, bus.obj_ready}, 32'd1);
        check("idle_rom_cs", {31'd0, bus.rom_cs}, 32'd0);

        // RAM is not reset: empty both buffers through display readout
        sweep_line(0, 1'b0);
        swap();
        sweep_line(0, 1'b0);

        // scenario 1: basic two-half object
        send_obj(12'h123, 4'h5, 9'd16, 4'h3, 1'b0);
        serve_rom("s1h0", 20'h12350, 32'h87654321, 0);
        serve_rom("s1h1", 20'h12358, 32'h0000000F, 0);
        wait_idle("s1");
        swap();
        sweep_line(1, 1'b1);

        // scenario 2: wrap past column 511
        send_obj(12'h0AB, 4'h2, 9'd508, 4'h5, 1'b0);
        serve_rom("s2h0", 20'h0AB20, 32'h11111111, 0);
        serve_rom("s2h1", 20'h0AB28, 32'h11111111, 0);
        wait_idle("s2");
        swap();
        sweep_line(2, 1'b1);

        // scenario 3: slow ROM, then exactly one 8-clk DRAW pass
        send_obj(12'h001, 4'h0, 9'd100, 4'hA, 1'b0);
        serve_rom("s3h0", 20'h00100, 32'h00000002, 20);
        check("s3_draw_cs", {31'd0, bus.rom_cs}, 32'd0);
        check("s3_draw_state", {30'd0, state_dbg}, 32'd2);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("s3_draw_cs_low", {31'd0, bus.rom_cs}, 32'd0);
        end
        tick();
        check("s3_req2_cs", {31'd0, bus.rom_cs}, 32'd1);
        check("s3_req2_addr", {12'd0, bus.rom_addr}, 32'h00108);
        serve_rom("s3h1", 20'h00108, 32'h00000000, 0);
        wait_idle("s3");
        swap();
        sweep_line(3, 1'b1);

        // scenario 4: line_start aborts during the half-1 request
        send_obj(12'h3C4, 4'hF, 9'd200, 4'h7, 1'b0);
        serve_rom("s4h0", 20'h3C4F0, 32'h22222222, 0);
        begin
            int n = 0;
            while (!bus.rom_cs && n < 50) begin
                tick();
                n++;
            end
        end
        check("s4_req2_addr", {12'd0, bus.rom_addr}, 32'h3C4F8);
        swap();
        check("s4_abort_cs", {31'd0, bus.rom_cs}, 32'd0);
        check("s4_abort_busy", {31'd0, busy}, 32'd0);
        tick();
        check("s4_abort_ready", {31'd0, bus.obj_ready}, 32'd1);
        sweep_line(4, 1'b1);

        // scenario 5: readout clears, off-screen reads 0, output holds
        send_obj(12'h010, 4'h1, 9'd40, 4'hC, 1'b0);
        serve_rom("s5h0", 20'h01010, 32'h00000009, 0);
        serve_rom("s5h1", 20'h01018, 32'h00000000, 0);
        wait_idle("s5");
        swap();
        read_col(9'd296, v);
        check("s5_offscreen", {24'd0, v}, 32'h00);
        read_col(9'd40, v);
        check("s5_col40_first", {24'd0, v}, 32'hC9);
        hdump = 9'd41;
        repeat (3) tick();
        check("s5_hold", {24'd0, pxl_dout}, 32'hC9);
        read_col(9'd40, v);
        check("s5_col40_second", {24'd0, v}, 32'h00);
        sweep_line(5, 1'b1);

        // scenario 6: hflip
        send_obj(12'h050, 4'h1, 9'd0, 4'h6, 1'b1);
        serve_rom("s6h0", 20'h05010, 32'h00000001, 0);
        serve_rom("s6h1", 20'h05018, 32'h00000000, 0);
        wait_idle("s6");
        swap();
        sweep_line(6, 1'b1);

        // reset during a fetch drops the request; late rom_ok ignored
        send_obj(12'h7FF, 4'h3, 9'd60, 4'h2, 1'b0);
        check("rf_cs_before", {31'd0, bus.rom_cs}, 32'd1);
        rstn = 1'b0;
        tick();
        check("rf_cs", {31'd0, bus.rom_cs}, 32'd0);
        check("rf_addr", {12'd0, bus.rom_addr}, 32'd0);
        check("rf_busy", {31'd0, busy}, 32'd0);
        rstn = 1'b1;
        bus.rom_ok   = 1'b1;
        bus.rom_data = 32'hFFFFFFFF;
        tick();
        bus.rom_ok = 1'b0;
        tick();
        check("rf_late_ok_state", {30'd0, state_dbg}, 32'd0);
        check("rf_late_ok_cs", {31'd0, bus.rom_cs}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
